cci_afu_mux: RTL and testbench
==============================

// Module: cci_afu_mux
// PURPOSE
//  N-way CCI fabric switch between the CCI emulator and NUM_AFU cci_std_afu instances.
//  - Per-AFU, per-channel TX FIFOs; round-robin arbitration onto the single upstream C0/C1 TX.
//  - RX responses routed back using AFU-id bits stamped into mdata.
//  - CSR/UMsg traffic broadcast to all AFUs.
//  Sits in the ASE top level, replacing the 1:1 emulator-to-AFU wiring.
// PARAMETERS
//  NUM_AFU       2   number of AFU ports (>=2); ID_W = $clog2(NUM_AFU)
//  FIFO_DEPTH    16  entries per AFU per TX channel (power of 2, >=8)
//  AFU_SLACK     4   free entries remaining when afu almostfull asserts
//  MDATA_ID_MSB  12  MSB of the mdata field holding the AFU id, bits [MSB -: ID_W]
// PORTS
//  clk_32ui          in   1            CCI clock
//  sys_reset_n       in   1            async active-low reset
//  up_tx_c0_hdr/rdvalid           out  61/1     upstream C0 read request
//  up_tx_c1_hdr/data/wrvalid/intrvalid  out  61/512/1/1  upstream C1 write/interrupt request
//  up_tx_c0_almostfull, up_tx_c1_almostfull  in  1  upstream flow control
//  up_rx_c0_hdr/data  in  18/512       upstream C0 response header and data
//  up_rx_c0_{rd,wr,cfg,umsg,intr}valid  in  1 each  C0 response qualifiers
//  up_rx_c1_hdr       in   18          upstream C1 response header
//  up_rx_c1_{wr,intr}valid  in  1 each  C1 response qualifiers
//  afu_* (tx in / rx out)  [NUM_AFU] x same widths  per-AFU mirror of every up_* signal
//  afu_tx_c{0,1}_almostfull  out  [NUM_AFU]  per-AFU flow control
//  afu_overflow      out  [NUM_AFU]    sticky: AFU pushed into a full FIFO
//  afu_lp_initdone   out  [NUM_AFU]    registered copy of up_lp_initdone (in, 1)
// BEHAVIOUR
//  Reset: all valid outputs 0, FIFOs empty, RR pointers at AFU0, afu_overflow 0.
//   afu almostfull = 1 in reset; deasserts the first cycle after release.
//  TX push:
//   - rdvalid (C0) or wrvalid|intrvalid (C1) writes hdr[/data/intr flag] into that AFU's FIFO.
//   - On write, mdata[MDATA_ID_MSB -: ID_W] is overwritten with the AFU index.
//  AFU almostfull: asserted when count >= FIFO_DEPTH-AFU_SLACK; combinational from count.
//  Overflow: push while full -> entry dropped, afu_overflow[i] set until reset.
//  Arbitration (per channel, independent):
//   - Grant the first non-empty FIFO at or after rr_ptr, only when up almostfull == 0.
//   - Pop it; drive the registered up_tx output next cycle; rr_ptr <= grant+1 (wraps at NUM_AFU).
//   - Idle: valid 0, hdr/data hold.
//   - Push-to-upstream latency: 2 cycles minimum.
//   - Simultaneous push+pop on one FIFO: legal; count unchanged; legal at full.
//  RX C0/C1 rd/wr/intr response:
//   - Routed to AFU = hdr[MDATA_ID_MSB -: ID_W]; id bits zeroed; registered, 1-cycle latency.
//   - Id >= NUM_AFU: response dropped.
//  RX cfg/umsg: broadcast to every AFU, same 1-cycle register.
//  Reset mid-operation: FIFO contents and in-flight outputs discarded immediately (async).
// CONFIGURATION
//  CCI_MUX_STATS_EN defined:
//   - Adds afu_rd_cnt/afu_wr_cnt out [NUM_AFU][31:0]: granted requests per AFU.
//   - Counters wrap at 2^32 and reset to 0.
//  Undefined: those ports are tied to 0 and no counter logic is built.
// STRUCTURE
//  cci_mux_pkg:
//   - tx_c0_entry_t {hdr}, tx_c1_entry_t {hdr, data, intr}
//   - CCI_TX_HDR_W=61, CCI_RX_HDR_W=18, CCI_DATA_W=512
//   - function rr_pick(req, ptr)
//  Sub-module cci_mux_fifo:
//   - Parametrised width/depth synchronous FIFO with count, full, empty.
//   - Instantiated 2*NUM_AFU times.
// TESTING
//  1. NUM_AFU=2, both AFUs push 1 read every cycle for 8 cycles ->
//     upstream alternates 0,1,0,1,...; each RX response with id n reaches only AFU n, id bits 0.
//  2. up_tx_c1_almostfull=1, AFU0 pushes 12 writes ->
//     afu_tx_c1_almostfull[0]=1 after the 12th push; no up wrvalid; release -> 12 writes in order.
//  3. AFU1 pushes 17 writes with upstream stalled -> afu_overflow[1]=1, 16 entries delivered.
//  4. up_rx_c0_cfgvalid with hdr=0x0A5 ->
//     every AFU sees cfgvalid and hdr 0x0A5 one cycle later.
//  5. Reset asserted with 5 queued entries -> all valids 0 at once;
//     after release no stale entry is issued.
//  6. CCI_MUX_STATS_EN: AFU0 10 reads, AFU1 3 writes ->
//     afu_rd_cnt[0]=10, afu_wr_cnt[1]=3, all others 0.

Source files
------------

// File: rtl/cci_mux_pkg.sv
// Shared types, widths and the round-robin helper for the CCI N-way fabric switch.
package cci_mux_pkg;

  localparam int unsigned CCI_TX_HDR_W = 61;
  localparam int unsigned CCI_RX_HDR_W = 18;
  localparam int unsigned CCI_DATA_W   = 512;
  localparam int unsigned RR_MAX       = 32;

  typedef struct packed {
    logic [CCI_TX_HDR_W-1:0] hdr;
  } tx_c0_entry_t;

  typedef struct packed {
    logic [CCI_TX_HDR_W-1:0] hdr;
    logic [CCI_DATA_W-1:0]   data;
    logic                    intr;
  } tx_c1_entry_t;

  // First requester at or after ptr, wrapping at n. Result is only meaningful when |req.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned           pick;
    logic                  found;
    logic [$clog2(RR_MAX)-1:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned off = 0; off < RR_MAX; off++) begin
      idx = ($clog2(RR_MAX))'((ptr + off) % n);
      if (!found && (off < n) && req[idx]) begin
        pick  = 32'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cci_mux_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; push at full is dropped
// unless a pop happens in the same cycle.
module cci_mux_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cci_afu_mux.sv
// N-way CCI switch: per-AFU TX FIFOs arbitrated round-robin upstream, RX routed by mdata id.
// Optional per-AFU grant counters are built when CCI_MUX_STATS_EN is defined.
module cci_afu_mux
  import cci_mux_pkg::*;
#(
  parameter int unsigned NUM_AFU      = 2,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AFU_SLACK    = 4,
  parameter int unsigned MDATA_ID_MSB = 12
) (
  input  logic                                    clk_32ui,
  input  logic                                    sys_reset_n,
  output logic [CCI_TX_HDR_W-1:0]                 up_tx_c0_hdr,
  output logic                                    up_tx_c0_rdvalid,
  output logic [CCI_TX_HDR_W-1:0]                 up_tx_c1_hdr,
  output logic [CCI_DATA_W-1:0]                   up_tx_c1_data,
  output logic                                    up_tx_c1_wrvalid,
  output logic                                    up_tx_c1_intrvalid,
  input  logic                                    up_tx_c0_almostfull,
  input  logic                                    up_tx_c1_almostfull,
  input  logic [CCI_RX_HDR_W-1:0]                 up_rx_c0_hdr,
  input  logic [CCI_DATA_W-1:0]                   up_rx_c0_data,
  input  logic                                    up_rx_c0_rdvalid,
  input  logic                                    up_rx_c0_wrvalid,
  input  logic                                    up_rx_c0_cfgvalid,
  input  logic                                    up_rx_c0_umsgvalid,
  input  logic                                    up_rx_c0_intrvalid,
  input  logic [CCI_RX_HDR_W-1:0]                 up_rx_c1_hdr,
  input  logic                                    up_rx_c1_wrvalid,
  input  logic                                    up_rx_c1_intrvalid,
  input  logic                                    up_lp_initdone,
  input  logic [NUM_AFU-1:0][CCI_TX_HDR_W-1:0]    afu_tx_c0_hdr,
  input  logic [NUM_AFU-1:0]                      afu_tx_c0_rdvalid,
  input  logic [NUM_AFU-1:0][CCI_TX_HDR_W-1:0]    afu_tx_c1_hdr,
  input  logic [NUM_AFU-1:0][CCI_DATA_W-1:0]      afu_tx_c1_data,
  input  logic [NUM_AFU-1:0]                      afu_tx_c1_wrvalid,
  input  logic [NUM_AFU-1:0]                      afu_tx_c1_intrvalid,
  output logic [NUM_AFU-1:0]                      afu_tx_c0_almostfull,
  output logic [NUM_AFU-1:0]                      afu_tx_c1_almostfull,
  output logic [NUM_AFU-1:0][CCI_RX_HDR_W-1:0]    afu_rx_c0_hdr,
  output logic [NUM_AFU-1:0][CCI_DATA_W-1:0]      afu_rx_c0_data,
  output logic [NUM_AFU-1:0]                      afu_rx_c0_rdvalid,
  output logic [NUM_AFU-1:0]                      afu_rx_c0_wrvalid,
  output logic [NUM_AFU-1:0]                      afu_rx_c0_cfgvalid,
  output logic [NUM_AFU-1:0]                      afu_rx_c0_umsgvalid,
  output logic [NUM_AFU-1:0]                      afu_rx_c0_intrvalid,
  output logic [NUM_AFU-1:0][CCI_RX_HDR_W-1:0]    afu_rx_c1_hdr,
  output logic [NUM_AFU-1:0]                      afu_rx_c1_wrvalid,
  output logic [NUM_AFU-1:0]                      afu_rx_c1_intrvalid,
  output logic [NUM_AFU-1:0]                      afu_overflow,
  output logic [NUM_AFU-1:0]                      afu_lp_initdone,
  output logic [NUM_AFU-1:0][31:0]                afu_rd_cnt,
  output logic [NUM_AFU-1:0][31:0]                afu_wr_cnt
);

  localparam int unsigned     ID_W    = $clog2(NUM_AFU);
  localparam int unsigned     CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] AfLevel = CNT_W'(FIFO_DEPTH - AFU_SLACK);
  localparam logic [ID_W-1:0]  LastId  = ID_W'(NUM_AFU - 1);

  tx_c0_entry_t       c0_head [NUM_AFU];
  tx_c1_entry_t       c1_head [NUM_AFU];
  logic [CNT_W-1:0]   c0_count [NUM_AFU];
  logic [CNT_W-1:0]   c1_count [NUM_AFU];
  logic [NUM_AFU-1:0] c0_push, c1_push, c0_pop, c1_pop;
  logic [NUM_AFU-1:0] c0_full, c1_full, c0_empty, c1_empty;
  logic               init_q;

  for (genvar i = 0; i < NUM_AFU; i++) begin : g_afu
    tx_c0_entry_t c0_wr;
    tx_c1_entry_t c1_wr;

    // Stamp the AFU index into mdata so responses can be routed back.
    always_comb begin
      c0_wr.hdr                      = afu_tx_c0_hdr[i];
      c0_wr.hdr[MDATA_ID_MSB -: ID_W] = ID_W'(i);
      c1_wr.hdr                      = afu_tx_c1_hdr[i];
      c1_wr.hdr[MDATA_ID_MSB -: ID_W] = ID_W'(i);
      c1_wr.data                     = afu_tx_c1_data[i];
      c1_wr.intr                     = afu_tx_c1_intrvalid[i];
    end

    assign c0_push[i] = afu_tx_c0_rdvalid[i];
    assign c1_push[i] = afu_tx_c1_wrvalid[i] | afu_tx_c1_intrvalid[i];
    assign afu_tx_c0_almostfull[i] = init_q | (c0_count[i] >= AfLevel);
    assign afu_tx_c1_almostfull[i] = init_q | (c1_count[i] >= AfLevel);

    cci_mux_fifo #(
      .Width($bits(tx_c0_entry_t)),
      .Depth(FIFO_DEPTH)
    ) u_c0_fifo (
      .clk_i  (clk_32ui),
      .rst_ni (sys_reset_n),
      .push_i (c0_push[i]),
      .wdata_i(c0_wr),
      .pop_i  (c0_pop[i]),
      .rdata_o(c0_head[i]),
      .count_o(c0_count[i]),
      .full_o (c0_full[i]),
      .empty_o(c0_empty[i])
    );

    cci_mux_fifo #(
      .Width($bits(tx_c1_entry_t)),
      .Depth(FIFO_DEPTH)
    ) u_c1_fifo (
      .clk_i  (clk_32ui),
      .rst_ni (sys_reset_n),
      .push_i (c1_push[i]),
      .wdata_i(c1_wr),
      .pop_i  (c1_pop[i]),
      .rdata_o(c1_head[i]),
      .count_o(c1_count[i]),
      .full_o (c1_full[i]),
      .empty_o(c1_empty[i])
    );
  end

  // Arbitration and upstream output registers
  logic [RR_MAX-1:0]       c0_req_ext, c1_req_ext;
  int unsigned             c0_pick, c1_pick;
  logic [ID_W-1:0]         c0_gnt, c1_gnt;
  logic                    c0_gnt_vld, c1_gnt_vld;
  logic [ID_W-1:0]         c0_ptr_q, c0_ptr_d, c1_ptr_q, c1_ptr_d;
  logic                    c0_vld_q, c0_vld_d, c1_wr_q, c1_wr_d, c1_intr_q, c1_intr_d;
  logic [CCI_TX_HDR_W-1:0] c0_hdr_q, c0_hdr_d, c1_hdr_q, c1_hdr_d;
  logic [CCI_DATA_W-1:0]   c1_data_q, c1_data_d;
  logic [NUM_AFU-1:0]      ovf_q, ovf_d;
  logic                    initdone_q;

  always_comb begin
    c0_req_ext                = '0;
    c0_req_ext[NUM_AFU-1:0]   = ~c0_empty;
    c1_req_ext                = '0;
    c1_req_ext[NUM_AFU-1:0]   = ~c1_empty;
    c0_pick    = rr_pick(c0_req_ext, 32'(c0_ptr_q), NUM_AFU);
    c1_pick    = rr_pick(c1_req_ext, 32'(c1_ptr_q), NUM_AFU);
    c0_gnt     = c0_pick[ID_W-1:0];
    c1_gnt     = c1_pick[ID_W-1:0];
    c0_gnt_vld = !up_tx_c0_almostfull && (|(~c0_empty));
    c1_gnt_vld = !up_tx_c1_almostfull && (|(~c1_empty));

    c0_pop    = '0;
    c1_pop    = '0;
    c0_ptr_d  = c0_ptr_q;
    c1_ptr_d  = c1_ptr_q;
    c0_vld_d  = c0_gnt_vld;
    c0_hdr_d  = c0_hdr_q;
    c1_wr_d   = 1'b0;
    c1_intr_d = 1'b0;
    c1_hdr_d  = c1_hdr_q;
    c1_data_d = c1_data_q;

    if (c0_gnt_vld) begin
      c0_pop[c0_gnt] = 1'b1;
      c0_hdr_d       = c0_head[c0_gnt].hdr;
      c0_ptr_d       = (c0_gnt == LastId) ? '0 : c0_gnt + ID_W'(1);
    end
    if (c1_gnt_vld) begin
      c1_pop[c1_gnt] = 1'b1;
      c1_hdr_d       = c1_head[c1_gnt].hdr;
      c1_data_d      = c1_head[c1_gnt].data;
      c1_wr_d        = !c1_head[c1_gnt].intr;
      c1_intr_d      = c1_head[c1_gnt].intr;
      c1_ptr_d       = (c1_gnt == LastId) ? '0 : c1_gnt + ID_W'(1);
    end

    ovf_d = ovf_q | (c0_push & c0_full & ~c0_pop) | (c1_push & c1_full & ~c1_pop);
  end

  // RX routing: rd/wr/intr go to the AFU named in mdata, cfg/umsg go to all.
  logic [ID_W-1:0]         c0_rx_id, c1_rx_id;
  logic [CCI_RX_HDR_W-1:0] rx_c0_hdr_q, rx_c0_hdr_d, rx_c1_hdr_q, rx_c1_hdr_d;
  logic [CCI_DATA_W-1:0]   rx_c0_data_q;
  logic [NUM_AFU-1:0]      rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d, rx_intr_q, rx_intr_d;
  logic [NUM_AFU-1:0]      rx_cfg_q, rx_umsg_q, rx_c1wr_q, rx_c1wr_d, rx_c1intr_q, rx_c1intr_d;

  always_comb begin
    c0_rx_id    = up_rx_c0_hdr[MDATA_ID_MSB -: ID_W];
    c1_rx_id    = up_rx_c1_hdr[MDATA_ID_MSB -: ID_W];
    rx_c0_hdr_d = up_rx_c0_hdr;
    if (!(up_rx_c0_cfgvalid || up_rx_c0_umsgvalid)) rx_c0_hdr_d[MDATA_ID_MSB -: ID_W] = '0;
    rx_c1_hdr_d = up_rx_c1_hdr;
    rx_c1_hdr_d[MDATA_ID_MSB -: ID_W] = '0;
    for (int i = 0; i < NUM_AFU; i++) begin
      rx_rd_d[i]     = up_rx_c0_rdvalid   && (c0_rx_id == ID_W'(i));
      rx_wr_d[i]     = up_rx_c0_wrvalid   && (c0_rx_id == ID_W'(i));
      rx_intr_d[i]   = up_rx_c0_intrvalid && (c0_rx_id == ID_W'(i));
      rx_c1wr_d[i]   = up_rx_c1_wrvalid   && (c1_rx_id == ID_W'(i));
      rx_c1intr_d[i] = up_rx_c1_intrvalid && (c1_rx_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk_32ui or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      init_q       <= 1'b1;
      initdone_q   <= 1'b0;
      ovf_q        <= '0;
      c0_ptr_q     <= '0;
      c1_ptr_q     <= '0;
      c0_vld_q     <= 1'b0;
      c0_hdr_q     <= '0;
      c1_wr_q      <= 1'b0;
      c1_intr_q    <= 1'b0;
      c1_hdr_q     <= '0;
      c1_data_q    <= '0;
      rx_c0_hdr_q  <= '0;
      rx_c1_hdr_q  <= '0;
      rx_c0_data_q <= '0;
      rx_rd_q      <= '0;
      rx_wr_q      <= '0;
      rx_intr_q    <= '0;
      rx_cfg_q     <= '0;
      rx_umsg_q    <= '0;
      rx_c1wr_q    <= '0;
      rx_c1intr_q  <= '0;
    end else begin
      init_q       <= 1'b0;
      initdone_q   <= up_lp_initdone;
      ovf_q        <= ovf_d;
      c0_ptr_q     <= c0_ptr_d;
      c1_ptr_q     <= c1_ptr_d;
      c0_vld_q     <= c0_vld_d;
      c0_hdr_q     <= c0_hdr_d;
      c1_wr_q      <= c1_wr_d;
      c1_intr_q    <= c1_intr_d;
      c1_hdr_q     <= c1_hdr_d;
      c1_data_q    <= c1_data_d;
      rx_c0_hdr_q  <= rx_c0_hdr_d;
      rx_c1_hdr_q  <= rx_c1_hdr_d;
      rx_c0_data_q <= up_rx_c0_data;
      rx_rd_q      <= rx_rd_d;
      rx_wr_q      <= rx_wr_d;
      rx_intr_q    <= rx_intr_d;
      rx_cfg_q     <= {NUM_AFU{up_rx_c0_cfgvalid}};
      rx_umsg_q    <= {NUM_AFU{up_rx_c0_umsgvalid}};
      rx_c1wr_q    <= rx_c1wr_d;
      rx_c1intr_q  <= rx_c1intr_d;
    end
  end

  assign up_tx_c0_hdr        = c0_hdr_q;
  assign up_tx_c0_rdvalid    = c0_vld_q;
  assign up_tx_c1_hdr        = c1_hdr_q;
  assign up_tx_c1_data       = c1_data_q;
  assign up_tx_c1_wrvalid    = c1_wr_q;
  assign up_tx_c1_intrvalid  = c1_intr_q;
  assign afu_overflow        = ovf_q;
  assign afu_lp_initdone     = {NUM_AFU{initdone_q}};
  assign afu_rx_c0_hdr       = {NUM_AFU{rx_c0_hdr_q}};
  assign afu_rx_c0_data      = {NUM_AFU{rx_c0_data_q}};
  assign afu_rx_c1_hdr       = {NUM_AFU{rx_c1_hdr_q}};
  assign afu_rx_c0_rdvalid   = rx_rd_q;
  assign afu_rx_c0_wrvalid   = rx_wr_q;
  assign afu_rx_c0_intrvalid = rx_intr_q;
  assign afu_rx_c0_cfgvalid  = rx_cfg_q;
  assign afu_rx_c0_umsgvalid = rx_umsg_q;
  assign afu_rx_c1_wrvalid   = rx_c1wr_q;
  assign afu_rx_c1_intrvalid = rx_c1intr_q;

`ifdef CCI_MUX_STATS_EN
  logic [NUM_AFU-1:0][31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (c0_gnt_vld) rd_cnt_d[c0_gnt] = rd_cnt_q[c0_gnt] + 32'd1;
    if (c1_gnt_vld && !c1_head[c1_gnt].intr) wr_cnt_d[c1_gnt] = wr_cnt_q[c1_gnt] + 32'd1;
  end

  always_ff @(posedge clk_32ui or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign afu_rd_cnt = rd_cnt_q;
  assign afu_wr_cnt = wr_cnt_q;
`else
  assign afu_rd_cnt = '0;
  assign afu_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_cci_afu_mux.sv
// Directed self-checking bench for cci_afu_mux (NUM_AFU=2, FIFO_DEPTH=16, AFU_SLACK=4).
module tb_cci_afu_mux;

  localparam int unsigned N = 2;

  logic              clk_32ui = 1'b0;
  logic              sys_reset_n;
  logic [60:0]       up_tx_c0_hdr, up_tx_c1_hdr;
  logic [511:0]      up_tx_c1_data;
  logic              up_tx_c0_rdvalid, up_tx_c1_wrvalid, up_tx_c1_intrvalid;
  logic              up_tx_c0_almostfull, up_tx_c1_almostfull;
  logic [17:0]       up_rx_c0_hdr, up_rx_c1_hdr;
  logic [511:0]      up_rx_c0_data;
  logic              up_rx_c0_rdvalid, up_rx_c0_wrvalid, up_rx_c0_cfgvalid;
  logic              up_rx_c0_umsgvalid, up_rx_c0_intrvalid;
  logic              up_rx_c1_wrvalid, up_rx_c1_intrvalid, up_lp_initdone;
  logic [N-1:0][60:0]  afu_tx_c0_hdr, afu_tx_c1_hdr;
  logic [N-1:0][511:0] afu_tx_c1_data;
  logic [N-1:0]      afu_tx_c0_rdvalid, afu_tx_c1_wrvalid, afu_tx_c1_intrvalid;
  logic [N-1:0]      afu_tx_c0_almostfull, afu_tx_c1_almostfull;
  logic [N-1:0][17:0]  afu_rx_c0_hdr, afu_rx_c1_hdr;
  logic [N-1:0][511:0] afu_rx_c0_data;
  logic [N-1:0]      afu_rx_c0_rdvalid, afu_rx_c0_wrvalid, afu_rx_c0_cfgvalid;
  logic [N-1:0]      afu_rx_c0_umsgvalid, afu_rx_c0_intrvalid;
  logic [N-1:0]      afu_rx_c1_wrvalid, afu_rx_c1_intrvalid;
  logic [N-1:0]      afu_overflow, afu_lp_initdone;
  logic [N-1:0][31:0]  afu_rd_cnt, afu_wr_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_32ui = ~clk_32ui;

  cci_afu_mux #(
    .NUM_AFU(N), .FIFO_DEPTH(16), .AFU_SLACK(4), .MDATA_ID_MSB(12)
  ) dut (
    .clk_32ui(clk_32ui), .sys_reset_n(sys_reset_n),
    .up_tx_c0_hdr(up_tx_c0_hdr), .up_tx_c0_rdvalid(up_tx_c0_rdvalid),
    .up_tx_c1_hdr(up_tx_c1_hdr), .up_tx_c1_data(up_tx_c1_data),
    .up_tx_c1_wrvalid(up_tx_c1_wrvalid), .up_tx_c1_intrvalid(up_tx_c1_intrvalid),
    .up_tx_c0_almostfull(up_tx_c0_almostfull), .up_tx_c1_almostfull(up_tx_c1_almostfull),
    .up_rx_c0_hdr(up_rx_c0_hdr), .up_rx_c0_data(up_rx_c0_data),
    .up_rx_c0_rdvalid(up_rx_c0_rdvalid), .up_rx_c0_wrvalid(up_rx_c0_wrvalid),
    .up_rx_c0_cfgvalid(up_rx_c0_cfgvalid), .up_rx_c0_umsgvalid(up_rx_c0_umsgvalid),
    .up_rx_c0_intrvalid(up_rx_c0_intrvalid), .up_rx_c1_hdr(up_rx_c1_hdr),
    .up_rx_c1_wrvalid(up_rx_c1_wrvalid), .up_rx_c1_intrvalid(up_rx_c1_intrvalid),
    .up_lp_initdone(up_lp_initdone),
    .afu_tx_c0_hdr(afu_tx_c0_hdr), .afu_tx_c0_rdvalid(afu_tx_c0_rdvalid),
    .afu_tx_c1_hdr(afu_tx_c1_hdr), .afu_tx_c1_data(afu_tx_c1_data),
    .afu_tx_c1_wrvalid(afu_tx_c1_wrvalid), .afu_tx_c1_intrvalid(afu_tx_c1_intrvalid),
    .afu_tx_c0_almostfull(afu_tx_c0_almostfull), .afu_tx_c1_almostfull(afu_tx_c1_almostfull),
    .afu_rx_c0_hdr(afu_rx_c0_hdr), .afu_rx_c0_data(afu_rx_c0_data),
    .afu_rx_c0_rdvalid(afu_rx_c0_rdvalid), .afu_rx_c0_wrvalid(afu_rx_c0_wrvalid),
    .afu_rx_c0_cfgvalid(afu_rx_c0_cfgvalid), .afu_rx_c0_umsgvalid(afu_rx_c0_umsgvalid),
    .afu_rx_c0_intrvalid(afu_rx_c0_intrvalid), .afu_rx_c1_hdr(afu_rx_c1_hdr),
    .afu_rx_c1_wrvalid(afu_rx_c1_wrvalid), .afu_rx_c1_intrvalid(afu_rx_c1_intrvalid),
    .afu_overflow(afu_overflow), .afu_lp_initdone(afu_lp_initdone),
    .afu_rd_cnt(afu_rd_cnt), .afu_wr_cnt(afu_wr_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_32ui);
    #1;
  endtask

  task automatic idle_tx();
    afu_tx_c0_rdvalid   = '0;
    afu_tx_c1_wrvalid   = '0;
    afu_tx_c1_intrvalid = '0;
  endtask

  function automatic logic [60:0] t1_hdr_in(input int a, input int k);
    return 61'h0AB0_0000 | 61'(k << 4) | 61'(a) | 61'((1 - a) << 12);
  endfunction

  function automatic logic [60:0] t1_hdr_exp(input int a, input int k);
    return 61'h0AB0_0000 | 61'(k << 4) | 61'(a) | 61'(a << 12);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int rd_seen;
    int wr_seen;
    sys_reset_n = 1'b0;
    up_tx_c0_almostfull = 1'b0; up_tx_c1_almostfull = 1'b0;
    up_rx_c0_hdr = '0; up_rx_c0_data = '0; up_rx_c1_hdr = '0;
    up_rx_c0_rdvalid = 1'b0; up_rx_c0_wrvalid = 1'b0; up_rx_c0_cfgvalid = 1'b0;
    up_rx_c0_umsgvalid = 1'b0; up_rx_c0_intrvalid = 1'b0;
    up_rx_c1_wrvalid = 1'b0; up_rx_c1_intrvalid = 1'b0; up_lp_initdone = 1'b0;
    afu_tx_c0_hdr = '0; afu_tx_c1_hdr = '0; afu_tx_c1_data = '0;
    idle_tx();
    step(); step();

    // Reset state
    check("rst_c0_valid", 64'(up_tx_c0_rdvalid), 64'd0);
    check("rst_c1_valid", 64'({up_tx_c1_wrvalid, up_tx_c1_intrvalid}), 64'd0);
    check("rst_af_c0", 64'(afu_tx_c0_almostfull), 64'd3);
    check("rst_af_c1", 64'(afu_tx_c1_almostfull), 64'd3);
    check("rst_ovf", 64'(afu_overflow), 64'd0);
    check("rst_rx_rd", 64'(afu_rx_c0_rdvalid), 64'd0);
    sys_reset_n = 1'b1;
    up_lp_initdone = 1'b1;
    #1;
    check("rel_af_held", 64'(afu_tx_c0_almostfull), 64'd3);
    step();
    check("rel_af_c0_clear", 64'(afu_tx_c0_almostfull), 64'd0);
    check("rel_af_c1_clear", 64'(afu_tx_c1_almostfull), 64'd0);
    check("initdone", 64'(afu_lp_initdone), 64'd3);

    // Test 1: both AFUs read every cycle, upstream alternates AFU0/AFU1
    for (int c = 0; c < 18; c++) begin
      if (c < 8) begin
        afu_tx_c0_rdvalid = 2'b11;
        afu_tx_c0_hdr[0] = t1_hdr_in(0, c);
        afu_tx_c0_hdr[1] = t1_hdr_in(1, c);
      end else begin
        idle_tx();
      end
      step();
      if (c == 0 || c == 17) begin
        check("t1_idle", 64'(up_tx_c0_rdvalid), 64'd0);
      end else begin
        check("t1_valid", 64'(up_tx_c0_rdvalid), 64'd1);
        check("t1_hdr", 64'(up_tx_c0_hdr), 64'(t1_hdr_exp((c - 1) % 2, (c - 1) / 2)));
      end
    end

    // RX routing by mdata id
    up_rx_c0_hdr = 18'h10AB; up_rx_c0_data = {16{32'hDEAD0001}}; up_rx_c0_rdvalid = 1'b1;
    step();
    check("rx_rd_id1_vld", 64'(afu_rx_c0_rdvalid), 64'd2);
    check("rx_rd_id1_hdr", 64'(afu_rx_c0_hdr[1]), 64'h00AB);
    check("rx_rd_id1_data", 64'(afu_rx_c0_data[1][31:0]), 64'hDEAD0001);
    up_rx_c0_hdr = 18'h20CD;
    step();
    check("rx_rd_id0_vld", 64'(afu_rx_c0_rdvalid), 64'd1);
    check("rx_rd_id0_hdr", 64'(afu_rx_c0_hdr[0]), 64'h20CD);
    up_rx_c0_rdvalid = 1'b0;
    up_rx_c1_hdr = 18'h1055; up_rx_c1_wrvalid = 1'b1;
    step();
    check("rx_rd_clear", 64'(afu_rx_c0_rdvalid), 64'd0);
    check("rx_c1_wr_vld", 64'(afu_rx_c1_wrvalid), 64'd2);
    check("rx_c1_wr_hdr", 64'(afu_rx_c1_hdr[1]), 64'h0055);
    up_rx_c1_wrvalid = 1'b0;
    up_rx_c1_hdr = 18'h0077; up_rx_c1_intrvalid = 1'b1;
    step();
    check("rx_c1_intr_vld", 64'(afu_rx_c1_intrvalid), 64'd1);
    up_rx_c1_intrvalid = 1'b0;

    // Test 2: upstream C1 stalled, AFU0 queues 12 writes
    up_tx_c1_almostfull = 1'b1;
    for (int k = 0; k < 12; k++) begin
      afu_tx_c1_wrvalid[0] = 1'b1;
      afu_tx_c1_hdr[0] = 61'h2000 | 61'(k);
      afu_tx_c1_data[0] = {16{32'hA000_0000 + 32'(k)}};
      step();
      if (k == 10) check("t2_af_at11", 64'(afu_tx_c1_almostfull[0]), 64'd0);
    end
    idle_tx();
    check("t2_af_at12", 64'(afu_tx_c1_almostfull[0]), 64'd1);
    check("t2_af_afu1", 64'(afu_tx_c1_almostfull[1]), 64'd0);
    check("t2_stalled", 64'(up_tx_c1_wrvalid), 64'd0);
    up_tx_c1_almostfull = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("t2_wr_vld", 64'(up_tx_c1_wrvalid), 64'd1);
      check("t2_wr_data", 64'(up_tx_c1_data[31:0]), 64'(32'hA000_0000 + 32'(k)));
    end
    check("t2_wr_hdr_last", 64'(up_tx_c1_hdr), 64'h200B);
    step();
    check("t2_drained", 64'(up_tx_c1_wrvalid), 64'd0);

    // Test 3: AFU1 overflows its C1 FIFO
    up_tx_c1_almostfull = 1'b1;
    for (int k = 0; k < 17; k++) begin
      afu_tx_c1_wrvalid[1] = 1'b1;
      afu_tx_c1_hdr[1] = 61'(k);
      afu_tx_c1_data[1] = {16{32'hB000_0000 + 32'(k)}};
      step();
      if (k == 15) check("t3_no_ovf_at16", 64'(afu_overflow), 64'd0);
    end
    idle_tx();
    check("t3_ovf", 64'(afu_overflow), 64'd2);
    check("t3_af", 64'(afu_tx_c1_almostfull[1]), 64'd1);
    up_tx_c1_almostfull = 1'b0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (up_tx_c1_wrvalid) begin
        check("t3_data", 64'(up_tx_c1_data[31:0]), 64'(32'hB000_0000 + 32'(got)));
        check("t3_hdr", 64'(up_tx_c1_hdr), 64'h1000 | 64'(got));
        got++;
      end
    end
    check("t3_delivered", 64'(got), 64'd16);
    check("t3_ovf_sticky", 64'(afu_overflow), 64'd2);

    // Test 4: cfg broadcast
    up_rx_c0_hdr = 18'h0A5; up_rx_c0_cfgvalid = 1'b1;
    step();
    up_rx_c0_cfgvalid = 1'b0;
    check("t4_cfg_vld", 64'(afu_rx_c0_cfgvalid), 64'd3);
    check("t4_hdr0", 64'(afu_rx_c0_hdr[0]), 64'h0A5);
    check("t4_hdr1", 64'(afu_rx_c0_hdr[1]), 64'h0A5);
    check("t4_no_rd", 64'(afu_rx_c0_rdvalid), 64'd0);
    step();
    check("t4_cfg_clear", 64'(afu_rx_c0_cfgvalid), 64'd0);

    // Interrupt request flows out as intrvalid, not wrvalid
    afu_tx_c1_intrvalid[1] = 1'b1; afu_tx_c1_hdr[1] = 61'h0042;
    step();
    idle_tx();
    step();
    check("intr_vld", 64'({up_tx_c1_wrvalid, up_tx_c1_intrvalid}), 64'd1);
    check("intr_hdr", 64'(up_tx_c1_hdr), 64'h1042);

    // Test 5: reset with entries queued and one request in flight
    up_tx_c0_almostfull = 1'b1;
    afu_tx_c0_rdvalid = 2'b11; step();
    afu_tx_c0_rdvalid = 2'b11; step();
    afu_tx_c0_rdvalid = 2'b01; step();
    idle_tx();
    up_tx_c0_almostfull = 1'b0;
    step();
    check("t5_inflight", 64'(up_tx_c0_rdvalid), 64'd1);
    up_tx_c0_almostfull = 1'b1;
    #2;
    sys_reset_n = 1'b0;
    #1;
    check("t5_async_c0", 64'(up_tx_c0_rdvalid), 64'd0);
    check("t5_async_af", 64'(afu_tx_c0_almostfull), 64'd3);
    check("t5_async_ovf", 64'(afu_overflow), 64'd0);
    step(); step();
    up_tx_c0_almostfull = 1'b0;
    sys_reset_n = 1'b1;
    rd_seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (up_tx_c0_rdvalid) rd_seen++;
    end
    check("t5_no_stale", 64'(rd_seen), 64'd0);

    // Test 6: grant statistics
    rd_seen = 0;
    wr_seen = 0;
    for (int c = 0; c < 25; c++) begin
      afu_tx_c0_rdvalid[0] = (c < 10);
      afu_tx_c1_wrvalid[1] = (c < 3);
      step();
      if (up_tx_c0_rdvalid) rd_seen++;
      if (up_tx_c1_wrvalid) wr_seen++;
    end
    idle_tx();
    check("t6_rd_seen", 64'(rd_seen), 64'd10);
    check("t6_wr_seen", 64'(wr_seen), 64'd3);
`ifdef CCI_MUX_STATS_EN
    check("t6_rd_cnt0", 64'(afu_rd_cnt[0]), 64'd10);
    check("t6_wr_cnt1", 64'(afu_wr_cnt[1]), 64'd3);
`else
    check("t6_rd_cnt0", 64'(afu_rd_cnt[0]), 64'd0);
    check("t6_wr_cnt1", 64'(afu_wr_cnt[1]), 64'd0);
`endif
    check("t6_rd_cnt1", 64'(afu_rd_cnt[1]), 64'd0);
    check("t6_wr_cnt0", 64'(afu_wr_cnt[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
